// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver.
// Captures each character once, stores {fe, byte} in a circular FIFO, and exposes a first-word-fall-through read port.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          rdrf,
    input  logic [7:0]    rx_data,
    input  logic          fe,
    output logic          rdrf_clr,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_fe,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          ovf,
    input  logic          ovf_clr
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t        state_r;
    state_t        state_s;
    logic          wr_req_s;
    logic          wr_ok_s;
    logic          rd_ok_s;
    logic          drop_s;
    logic          empty_s;
    logic          full_s;
    logic [AW-1:0] wp_r;
    logic [AW-1:0] rp_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_s;
    logic          ovf_r;
    logic [8:0]    mem_r [DEPTH];
    logic [8:0]    head_s;

    assign empty_s = (count_r == {(AW + 1){1'b0}});
    assign full_s  = (count_r == FULL_CNT);
    // Full is judged on the pre-edge count, so a capture while full drops even if a pop frees a slot.
    assign wr_ok_s = wr_req_s & ~full_s;
    assign drop_s  = wr_req_s & full_s;
    assign rd_ok_s = rd_en & ~empty_s;
    assign head_s  = mem_r[rp_r];

    // Capture FSM next-state: one capture per rdrf assertion.
    always_comb begin
        state_s  = state_r;
        wr_req_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rdrf) begin
                    wr_req_s = 1'b1;
                    state_s  = ACK;
                end else begin
                    state_s  = IDLE;
                end
            end
            ACK: begin
                if (!rdrf) begin
                    state_s = IDLE;
                end else begin
                    state_s = ACK;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Occupancy next value: write-only increments, read-only decrements.
    always_comb begin
        count_s = count_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // Control state, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= IDLE;
            wp_r    <= {AW{1'b0}};
            rp_r    <= {AW{1'b0}};
            count_r <= {(AW + 1){1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            if (wr_ok_s) begin
                wp_r <= wp_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rp_r <= rp_r + PTR_ONE;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Entry storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wp_r] <= {fe, rx_data};
        end
    end

    assign rdrf_clr = (state_r == ACK);
    assign rd_data  = empty_s ? 8'h00 : head_s[7:0];
    assign rd_fe    = empty_s ? 1'b0  : head_s[8];
    assign empty    = empty_s;
    assign full     = full_s;
    assign count    = count_r;
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios then random traffic against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        rdrf;
    logic [7:0]  rx_data;
    logic        fe;
    logic        rdrf_clr;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_fe;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        ovf;
    logic        ovf_clr;

    int tests = 0;
    int fails = 0;

    logic [8:0] mq [$];
    bit         m_ovf;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .clr(clr), .rdrf(rdrf), .rx_data(rx_data), .fe(fe),
        .rdrf_clr(rdrf_clr), .rd_en(rd_en), .rd_data(rd_data), .rd_fe(rd_fe),
        .empty(empty), .full(full), .count(count), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock: cap_new marks a fresh character the model must capture.
    task automatic step(input bit cap_new, input bit hold_rdrf, input logic [7:0] b,
                        input bit f, input bit pop, input bit oclr);
        bit full_pre;
        bit empty_pre;
        rdrf    = cap_new | hold_rdrf;
        rx_data = b;
        fe      = f;
        rd_en   = pop;
        ovf_clr = oclr;
        full_pre  = (mq.size() == DEPTH);
        empty_pre = (mq.size() == 0);
        tick();
        if (cap_new && !full_pre) mq.push_back({f, b});
        if (cap_new && full_pre) m_ovf = 1'b1;
        else if (oclr) m_ovf = 1'b0;
        if (pop && !empty_pre) void'(mq.pop_front());
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b, input bit f, input int hold, input bit pop);
        step(1'b1, 1'b0, b, f, pop, 1'b0);
        chk("rdrf_clr_rise", rdrf_clr, 1);
        for (int k = 1; k < hold; k++) begin
            step(1'b0, 1'b1, b, f, 1'b0, 1'b0);
            chk("rdrf_clr_held", rdrf_clr, 1);
        end
        step(1'b0, 1'b0, b, f, 1'b0, 1'b0);
        chk("rdrf_clr_fall", rdrf_clr, 0);
    endtask

    task automatic pop1();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_all(input string tag);
        logic [8:0] head;
        head = (mq.size() != 0) ? mq[0] : 9'h000;
        chk({tag, "_rd_data"}, rd_data, head[7:0]);
        chk({tag, "_rd_fe"},   rd_fe,   head[8]);
        chk({tag, "_empty"},   empty,   mq.size() == 0);
        chk({tag, "_full"},    full,    mq.size() == DEPTH);
        chk({tag, "_count"},   count,   mq.size());
        chk({tag, "_ovf"},     ovf,     m_ovf);
    endtask

    initial begin
        clr = 1'b1; rdrf = 1'b0; rx_data = 8'h00; fe = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
        m_ovf = 1'b0;
        #1;
        chk("reset_rdrf_clr", rdrf_clr, 0);
        check_all("reset");
        tick();
        tick();
        clr = 1'b0;

        // Single byte held three cycles.
        rx(8'hA5, 1'b0, 3, 1'b0);
        chk("single_count", count, 1);
        chk("single_data", rd_data, 8'hA5);
        chk("single_fe", rd_fe, 0);
        check_all("single");

        // Framing error entry.
        rx(8'h3C, 1'b1, 1, 1'b0);
        pop1();
        chk("fe_head_data", rd_data, 8'h3C);
        chk("fe_head_flag", rd_fe, 1);
        pop1();
        chk("fe_pop_empty", empty, 1);
        chk("fe_pop_data", rd_data, 8'h00);
        check_all("fe");

        // Fill past capacity.
        for (int i = 0; i < 17; i++) rx(8'(i), 1'b0, 1, 1'b0);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_ovf", ovf, 1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_cleared", ovf, 0);
        step(1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b1);
        chk("ovf_set_wins", ovf, 1);
        step(1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0);
        check_all("fill");
        for (int i = 0; i < 16; i++) begin
            chk("fill_order", rd_data, i);
            pop1();
        end
        chk("fill_drained", empty, 1);
        check_all("drain");

        // Reset in the middle of a handshake with five entries and ovf set.
        for (int i = 0; i < 4; i++) rx(8'h20 + 8'(i), 1'b0, 1, 1'b0);
        step(1'b1, 1'b0, 8'h24, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_count", count, 5);
        chk("pre_reset_ack", rdrf_clr, 1);
        #1 clr = 1'b1;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        chk("mid_reset_rdrf_clr", rdrf_clr, 0);
        chk("mid_reset_count", count, 0);
        chk("mid_reset_empty", empty, 1);
        chk("mid_reset_ovf", ovf, 0);
        check_all("mid_reset");
        #1 clr = 1'b0;
        step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("post_reset_count", count, 1);
        chk("post_reset_data", rd_data, 8'h77);
        step(1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
        pop1();
        check_all("post_reset");

        // Pointer wrap-around.
        for (int i = 0; i < 10; i++) rx(8'h40 + 8'(i), 1'b0, 1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("wrap_first_order", rd_data, 8'h40 + 8'(i));
            pop1();
        end
        for (int i = 0; i < 12; i++) rx(8'h80 + 8'(i), 1'b0, 1, 1'b0);
        chk("wrap_count", count, 12);
        check_all("wrap");

        // Simultaneous capture and pop.
        for (int i = 0; i < 4; i++) pop1();
        rx(8'hC1, 1'b0, 1, 1'b1);
        chk("simul_half_count", count, 8);
        chk("simul_half_head", rd_data, 8'h85);
        for (int i = 0; i < 8; i++) rx(8'hD0 + 8'(i), 1'b0, 1, 1'b0);
        rx(8'hEE, 1'b0, 1, 1'b1);
        chk("simul_full_count", count, 15);
        chk("simul_full_ovf", ovf, 1);
        check_all("simul");
        while (mq.size() != 0) begin
            check_all("simul_drain");
            pop1();
        end
        pop1();
        chk("pop_empty_count", count, 0);
        chk("pop_empty_flag", empty, 1);
        check_all("pop_empty");

        // Random traffic.
        for (int n = 0; n < 200; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4) rx(8'($urandom), 1'($urandom), $urandom_range(1, 3), 1'($urandom));
            else if (r <= 7) pop1();
            else if (r == 8) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            else step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each completed character (rdrf/rx_data/FE), acknowledges the receiver with rdrf_clr, and stores byte plus framing-error flag in a circular FIFO. The host side drains entries through a first-word-fall-through read port. Overflow is reported through a sticky flag.

## Interface
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- AW, 4: pointer width; log2(DEPTH).
- clk  in  1  system clock, rising edge.
- clr  in  1  reset; asynchronous, active-high.
- rdrf  in  1  receiver data-ready flag; high while a received byte is pending.
- rx_data  in  8  received byte; valid while rdrf=1.
- fe  in  1  receiver framing error for the pending byte; valid while rdrf=1.
- rdrf_clr  out  1  acknowledge to receiver; active-high, held until rdrf falls.
- rd_en  in  1  host pop request.
- rd_data  out  8  head entry byte; 0x00 when empty.
- rd_fe  out  1  head entry framing-error flag; 0 when empty.
- empty  out  1  no entries stored.
- full  out  1  DEPTH entries stored.
- count  out  AW+1  entries stored, 0..DEPTH.
- ovf  out  1  sticky overflow: a byte was dropped because the FIFO was full.
- ovf_clr  in  1  clears ovf, synchronous.

## Operation
- Storage: DEPTH x 9 bits, entry = {fe, rx_data}. Write pointer wp, read pointer rp, both AW bits, wrap modulo DEPTH. count is a separate AW+1-bit register.
- Capture FSM, 2 states:
  - IDLE: rdrf_clr=0. If rdrf=1: capture {fe, rx_data}. If not full, write mem[wp] and increment wp; if full, drop the byte and set ovf. Assert rdrf_clr and go to ACK.
  - ACK: rdrf_clr=1. If rdrf=0, deassert rdrf_clr and go to IDLE. Otherwise stay; no further capture.
- Each receiver character is captured exactly once, regardless of how long rdrf stays high.
- Read: when empty=0, rd_data/rd_fe = mem[rp] (combinational from the registered rp). rd_en=1 with empty=0 increments rp. rd_en with empty=1 is ignored; no pointer or count change.
- Count update per cycle: +1 on an accepted write only, −1 on an accepted read only, unchanged when both or neither occur.
- Full decision uses the pre-edge full state. A capture while full is dropped even if rd_en pops in the same cycle. That cycle is a read only, and count decrements.
- empty = (count==0); full = (count==DEPTH).
- ovf: set on a dropped capture; cleared by ovf_clr. Set wins when both occur in the same cycle.
- Reset (asynchronous, any state, mid-handshake included):
  - FSM goes to IDLE.
  - wp=rp=0, count=0.
  - rdrf_clr=0, ovf=0, empty=1, full=0, rd_data=0x00, rd_fe=0.
  - Memory contents are not reset.
  - If rdrf is still high after reset releases, the pending byte is captured as a new character.

## Timing
- Capture latency: rdrf sampled high at edge N. At that edge the entry is written, count updates, and rdrf_clr rises. Entry is visible on rd_data after edge N (empty falls at the same edge).
- rdrf_clr falls at the first edge where rdrf is sampled 0. Minimum pulse is 1 cycle.
- Minimum spacing between captures: rdrf must be low for at least one sampled edge before the next capture.
- Pop: rd_en sampled at edge M. rd_data shows the next entry (or 0x00 if now empty) after edge M.
- Write and pop in the same cycle are both honoured; count is unchanged.

## Test plan
- Single byte: rdrf=1 with rx_data=0xA5, fe=0, held 3 cycles then dropped. Expect exactly one entry, count=1, rd_data=0xA5, rd_fe=0. rdrf_clr is high from capture until the edge after rdrf falls.
- Framing error: capture 0x3C with fe=1. Expect rd_fe=1 at the head. Pop: empty=1, rd_data=0x00.
- Fill and overflow: 17 captures 0x00..0x10 with DEPTH=16. Expect full=1, count=16, ovf=1. Pops return 0x00..0x0F in order, and 0x10 is absent. ovf_clr then clears ovf.
- Wrap-around: 10 writes, 10 pops, then 12 writes. Expect correct FIFO order across the pointer wrap and count=12.
- Simultaneous events: full FIFO with capture and rd_en in the same cycle gives count 15 and ovf=1. Half-full FIFO with capture and rd_en together leaves count unchanged and the head advances. Pop while empty: no change.
- Reset mid-handshake: assert clr while in ACK with count=5. Expect immediately rdrf_clr=0, count=0, empty=1, ovf=0. With rdrf still high after clr release, one new capture occurs.
